lsu_core: RTL
=============

LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles awaiting mem_ready before the access is aborted with error.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: datapath presents a load/store.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3: RISC-V size/sign code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
REQ-007 SHALL have port req_addr, input, 32: byte address, driven by the ALU result.
REQ-008 SHALL have port req_wdata, input, 32: store data from register rs2.
REQ-009 SHALL have port req_ready, output, 1: request accepted this cycle.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32: extended load data, which feeds the datapath ReadData input.
REQ-012 SHALL have port rsp_err, output, 1: misaligned access, illegal funct3, or timeout; valid only with rsp_valid.
REQ-013 SHALL have port stall, output, 1: freezes the PC register and the register-file write.
REQ-014 SHALL have ports mem_valid output 1, mem_write output 1, mem_addr output 32, mem_wdata output 32, mem_wstrb output 4, mem_ready input 1, and mem_rdata input 32.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready.
REQ-017 SHALL, on acceptance of a legal aligned request, register the address, funct3, write flag and lane-formatted data, and then enter BUSY.
REQ-018 SHALL treat these as illegal: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 3/6/7, store funct3 >2; an illegal request goes IDLE->RESP with rsp_err=1, rsp_rdata=0, and no bus access.
REQ-019 SHALL, in BUSY, assert mem_valid with mem_addr = {addr[31:2],2'b00}; all mem_* outputs SHALL stay stable until mem_ready.
REQ-020 SHALL, for stores, drive mem_wdata with the byte replicated to 4 lanes (SB), the half replicated to 2 lanes (SH), or the word (SW); mem_wstrb = 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), or 1111 (SW).
REQ-021 SHALL, for loads, drive mem_wstrb=0 and mem_wdata=0.
REQ-022 SHALL, on mem_valid & mem_ready, capture mem_rdata >> (8*addr[1:0]), extended per funct3 (sign for LB/LH, zero for LBU/LHU), with stores returning 0; the FSM SHALL then go to RESP.
REQ-023 SHALL, for a zero-wait memory (mem_ready high in the first BUSY cycle), assert rsp_valid 2 cycles after acceptance; each wait cycle adds 1.
REQ-024 SHALL count BUSY cycles; when the count reaches TIMEOUT without mem_ready, mem_valid SHALL drop, and the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 SHALL, in RESP, assert rsp_valid for exactly 1 cycle and then return to IDLE; a new request SHALL NOT be accepted in RESP.
REQ-026 SHALL define stall = (IDLE & req_valid) | BUSY; stall SHALL be 0 in RESP, so the CPU advances in the same cycle as the writeback.
REQ-027 SHALL ignore mem_ready outside BUSY.
REQ-028 SHALL hold rsp_rdata and rsp_err until the next response.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: state IDLE, timeout counter 0, mem_valid 0, mem_write 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
REQ-030 SHALL abandon any in-flight access at reset assertion mid-BUSY, with no response emitted after release.
REQ-031 SHALL leave IDLE no earlier than the first rising edge after reset release.

Structure
REQ-032 SHALL place the funct3 encodings (LB..LHU, SB..SW) and the FSM state encoding in the shared package riscv_pkg.
REQ-033 SHALL implement lane steering as one combinational sub-module, lsu_align: store lane replication and strobe, plus load shift and extension.

Verification
REQ-034 SHALL cover LW at 0x100 with mem_ready in the first BUSY cycle and mem_rdata=0xDEADBEEF -> rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 SHALL cover LB at 0x103 with mem_rdata=0x80FF_FF00 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SHALL cover SH at 0x102 with req_wdata=0x1234ABCD -> mem_addr=0x100, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_write=1.
REQ-037 SHALL cover LW at 0x101 -> no mem_valid, rsp_valid the next cycle with rsp_err=1; funct3=3 load -> same.
REQ-038 SHALL cover TIMEOUT=4 with mem_ready held low -> mem_valid high for 4 cycles, then rsp_err=1; stall=1 throughout BUSY and 0 in RESP.
REQ-039 SHALL cover reset=0 asserted in the middle of a BUSY period with 3 wait cycles -> mem_valid=0 immediately, no rsp_valid after release, and the next request completing normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 load/store encodings, LSU FSM states and request legality check
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  function automatic logic lsu_legal(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    return (wr ? f3 <= F3_SW : (f3 <= F3_LW || f3 == F3_LBU || f3 == F3_LHU)) &&
           !(f3[1:0] == 2'd1 && a[0]) && !(f3[1:0] == 2'd2 && a != 2'd0);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobe and load shift/extension
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  output logic [31:0] o_ld_data
);
  logic [31:0] w_sh;
  assign w_sh = i_rdata >> {i_addr_lo, 3'b000};
  assign o_st_data = i_funct3 == F3_SB ? {4{i_wdata[7:0]}} :
                     i_funct3 == F3_SH ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_st_strb = i_funct3 == F3_SB ? 4'b0001 << i_addr_lo :
                     i_funct3 == F3_SH ? 4'b0011 << i_addr_lo : 4'b1111;
  assign o_ld_data = i_funct3 == F3_LB  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                     i_funct3 == F3_LH  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                     i_funct3 == F3_LW  ? w_sh :
                     i_funct3 == F3_LBU ? {24'b0, w_sh[7:0]} :
                     i_funct3 == F3_LHU ? {16'b0, w_sh[15:0]} : '0;
endmodule

// File: rtl/lsu_core.sv
// lsu_core: RISC-V load/store unit, IDLE/BUSY/RESP handshake to a word-wide memory bus
module lsu_core
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [2:0]    r_f3;
  logic [3:0]    r_wstrb;
  logic          r_write, r_err;
  logic          w_idle, w_busy, w_acc, w_legal, w_tmo;
  logic [2:0]    w_f3;
  logic [1:0]    w_alo;
  logic [31:0]   w_st_data, w_ld_data;
  logic [3:0]    w_st_strb;
  assign w_idle  = r_state == S_IDLE;
  assign w_busy  = r_state == S_BUSY;
  assign w_acc   = req_valid & w_idle;
  assign w_legal = lsu_legal(req_write, req_funct3, req_addr[1:0]);
  assign w_tmo   = r_cnt == CW'(TIMEOUT - 1);
  // Aligner sees the incoming request while idle, the latched one otherwise
  assign w_f3  = w_idle ? req_funct3 : r_f3;
  assign w_alo = w_idle ? req_addr[1:0] : r_addr[1:0];
  lsu_align u_align (
    .i_funct3 (w_f3),
    .i_addr_lo(w_alo),
    .i_wdata  (req_wdata),
    .i_rdata  (mem_rdata),
    .o_st_data(w_st_data),
    .o_st_strb(w_st_strb),
    .o_ld_data(w_ld_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_f3    <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_state <= w_legal ? S_BUSY : S_RESP;
      r_cnt   <= '0;
      if (w_legal) begin
        r_addr  <= req_addr;
        r_f3    <= req_funct3;
        r_write <= req_write;
        r_wdata <= req_write ? w_st_data : '0;
        r_wstrb <= req_write ? w_st_strb : '0;
      end else begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end else if (w_busy) begin
      if (mem_ready) begin
        r_state <= S_RESP;
        r_rdata <= r_write ? '0 : w_ld_data;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_state <= S_RESP;
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else
        r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_RESP)
      r_state <= S_IDLE;
  assign req_ready = w_idle;
  assign stall     = (w_idle & req_valid) | w_busy;
  assign mem_valid = w_busy;
  assign mem_write = r_write;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule
